exec_stage: RTL and testbench
=============================

// Module: exec_stage
// PURPOSE
//  Y86-64 execute stage with registered E->M pipeline latch. Selects ALU operands, runs the ALU,
//  holds condition codes (ZF/SF/OF) and evaluates jXX/cmovXX conditions. Sits between the decode
//  latch and memory stage; generalises operand prep to DATA_W and adds stall/bubble control.
// PARAMETERS
//  DATA_W   64  datapath width (>=16, multiple of 8); stack adjust constants are -8/+8 sign-extended
//  RNONE    4'hF  register id meaning "no destination"
// PORTS
//  clk_i        in   1       clock
//  rst_i        in   1       synchronous active-high reset
//  e_icode_i    in   4       instruction code (`define.v` encodings)
//  e_ifun_i     in   4       function code
//  e_valC_i     in   DATA_W  constant word
//  e_valA_i     in   DATA_W  operand A
//  e_valB_i     in   DATA_W  operand B
//  e_dstE_i     in   4       ALU destination register id
//  e_dstM_i     in   4       memory destination register id
//  set_cc_i     in   1       1 = CC update permitted this cycle (0 while a later stage has an exception)
//  m_stall_i    in   1       hold E->M latch
//  m_bubble_i   in   1       load NOP into E->M latch
//  busy_o       out  1       multi-cycle op in progress; upstream must stall (0 without ALU_MUL_EN)
//  e_cnd_o      out  1       combinational condition result for current jXX/cmovXX
//  m_icode_o    out  4       latched icode
//  m_cnd_o      out  1       latched condition
//  m_valE_o     out  DATA_W  latched ALU result
//  m_valA_o     out  DATA_W  latched valA pass-through
//  m_dstE_o     out  4       latched dstE (RNONE if cmov not taken)
//  m_dstM_o     out  4       latched dstM
// BEHAVIOUR
//  - Reset: m_icode_o=`NOP, m_cnd_o=0, m_valE_o=0, m_valA_o=0, m_dstE_o=m_dstM_o=RNONE,
//    CC={ZF,SF,OF}=3'b100, busy_o=0, multiplier FSM=IDLE.
//  - aluA: CXX,OPQ->valA; IRMOVQ,IOPQ,RMMOVQ,MRMOVQ->valC; CALL,PUSHQ->-8; RET,POPQ->+8; else 0.
//  - aluB: RMMOVQ,MRMOVQ,OPQ,IOPQ,CALL,PUSHQ,RET,POPQ->valB; CXX,IRMOVQ,others->0.
//  - fun: OPQ/IOPQ->ifun; else ADD. valE = aluB OP aluA: 0 ADD, 1 SUB (B-A), 2 AND, 3 XOR;
//    result truncated to DATA_W.
//  - Flags: ZF=(valE==0); SF=valE[DATA_W-1]; OF: ADD = A,B same sign and result sign differs;
//    SUB = B,A signs differ and result sign != B sign; AND/XOR OF=0.
//  - CC written at clock edge iff icode in {OPQ,IOPQ} & set_cc_i & !m_stall_i & !busy_o. New CC is
//    visible to the next instruction's e_cnd_o (one-cycle CC latency, no bypass).
//  - e_cnd_o (JXX/CXX only, else 0) by ifun: 0 1; 1 le=(SF^OF)|ZF; 2 l=SF^OF; 3 e=ZF; 4 ne=!ZF;
//    5 ge=!(SF^OF); 6 g=!(SF^OF)&!ZF; 7-15 -> 0.
//  - CXX with e_cnd_o=0 latches m_dstE_o=RNONE.
//  - Latch priority at edge: rst_i > m_stall_i (hold all) > m_bubble_i or busy_o (load reset values)
//    > load. Stall and bubble together: stall wins. CC not written on a bubbled cycle.
//  - Latency: one cycle from e_* inputs to m_* outputs for all single-cycle ops.
// CONFIGURATION
//  ALU_MUL_EN defined: OPQ/IOPQ ifun 4 = MUL (valE = low DATA_W bits of aluB*aluA, unsigned
//    shift-add). FSM IDLE->MUL on MUL with !m_stall_i; MUL iterates DATA_W cycles with busy_o=1
//    (operands captured at entry, inputs ignored, latch fed bubbles); MUL->DONE emits result on the
//    next unstalled edge with CC update (OF=0 when the high product half is zero, else 1), DONE->IDLE.
//    m_stall_i in MUL freezes the FSM. rst_i mid-op -> IDLE, busy_o=0, result discarded.
//  ALU_MUL_EN undefined: ifun 4 -> valE=0, CC not written, busy_o tied 0, no FSM logic.
// TESTING
//  1 Reset: rst_i=1 one edge -> m_icode_o=`NOP, m_dstE_o=4'hF, CC=3'b100, busy_o=0.
//  2 OPQ ADD valA=1,valB=7FFF..FF -> m_valE_o=8000..00, next cycle CC: ZF=0,SF=1,OF=1.
//  3 OPQ SUB valA=5,valB=5 then CXX ifun 3 -> e_cnd_o=1, m_dstE_o=e_dstE_i; ifun 4 -> m_dstE_o=4'hF.
//  4 PUSHQ valB=0x100 -> m_valE_o=0xF8; POPQ valB=0x100 -> 0x108; CC unchanged.
//  5 m_stall_i=1 with new inputs -> m_* hold, CC hold; stall+bubble -> hold; bubble alone -> NOP.
//  6 ALU_MUL_EN: MUL valA=3,valB=7 -> busy_o high DATA_W cycles, m_valE_o=21; reset mid-op -> idle.

Source files
------------

// File: rtl/exec_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, jXX/cmovXX evaluation and E->M latch.
// Optional shift-add multiplier (OPQ/IOPQ ifun 4) is built when ALU_MUL_EN is defined.
module exec_stage #(
  parameter int unsigned DATA_W = 64,
  parameter logic [3:0]  RNONE  = 4'hF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        e_icode_i,
  input  logic [3:0]        e_ifun_i,
  input  logic [DATA_W-1:0] e_valC_i,
  input  logic [DATA_W-1:0] e_valA_i,
  input  logic [DATA_W-1:0] e_valB_i,
  input  logic [3:0]        e_dstE_i,
  input  logic [3:0]        e_dstM_i,
  input  logic              set_cc_i,
  input  logic              m_stall_i,
  input  logic              m_bubble_i,
  output logic              busy_o,
  output logic              e_cnd_o,
  output logic [3:0]        m_icode_o,
  output logic              m_cnd_o,
  output logic [DATA_W-1:0] m_valE_o,
  output logic [DATA_W-1:0] m_valA_o,
  output logic [3:0]        m_dstE_o,
  output logic [3:0]        m_dstM_o
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CXX    = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_IOPQ   = 4'hC;
  localparam logic [3:0] F_ADD    = 4'h0;
  localparam logic [3:0] F_SUB    = 4'h1;
  localparam logic [3:0] F_AND    = 4'h2;
  localparam logic [3:0] F_XOR    = 4'h3;
  localparam int unsigned MSB     = DATA_W - 1;
  localparam logic [DATA_W-1:0] STK_DEC = {{(DATA_W-4){1'b1}}, 4'h8};
  localparam logic [DATA_W-1:0] STK_INC = DATA_W'(8);

  logic [DATA_W-1:0] alu_a, alu_b, val_e;
  logic [3:0]        fun, dst_e_sel;
  logic              is_op, alu_ok, of_flag;
  logic [2:0]        cc_q, cc_new;
  logic              cc_we, mul_start, mul_emit;
  logic [3:0]        src_icode, src_dst_e, src_dst_m;
  logic              src_cnd;
  logic [DATA_W-1:0] src_val_e, src_val_a;

  assign is_op  = (e_icode_i == I_OPQ) || (e_icode_i == I_IOPQ);
  assign fun    = is_op ? e_ifun_i : F_ADD;
  assign alu_ok = (fun <= F_XOR);

  // Operand selection
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (e_icode_i)
      I_CXX, I_OPQ:                         alu_a = e_valA_i;
      I_IRMOVQ, I_IOPQ, I_RMMOVQ, I_MRMOVQ: alu_a = e_valC_i;
      I_CALL, I_PUSHQ:                      alu_a = STK_DEC;
      I_RET, I_POPQ:                        alu_a = STK_INC;
      default:                              alu_a = '0;
    endcase
    case (e_icode_i)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_IOPQ,
      I_CALL, I_PUSHQ, I_RET, I_POPQ:       alu_b = e_valB_i;
      default:                              alu_b = '0;
    endcase
  end

  // ALU computes aluB OP aluA
  always_comb begin
    val_e   = '0;
    of_flag = 1'b0;
    case (fun)
      F_ADD: begin
        val_e   = alu_b + alu_a;
        of_flag = (alu_a[MSB] == alu_b[MSB]) && (val_e[MSB] != alu_a[MSB]);
      end
      F_SUB: begin
        val_e   = alu_b - alu_a;
        of_flag = (alu_b[MSB] != alu_a[MSB]) && (val_e[MSB] != alu_b[MSB]);
      end
      F_AND:   val_e = alu_b & alu_a;
      F_XOR:   val_e = alu_b ^ alu_a;
      default: val_e = '0;
    endcase
  end

  // Condition evaluation against the CC as of the start of this cycle
  always_comb begin
    e_cnd_o = 1'b0;
    if ((e_icode_i == I_JXX) || (e_icode_i == I_CXX)) begin
      case (e_ifun_i)
        4'h0:    e_cnd_o = 1'b1;
        4'h1:    e_cnd_o = (cc_q[1] ^ cc_q[0]) | cc_q[2];
        4'h2:    e_cnd_o = cc_q[1] ^ cc_q[0];
        4'h3:    e_cnd_o = cc_q[2];
        4'h4:    e_cnd_o = ~cc_q[2];
        4'h5:    e_cnd_o = ~(cc_q[1] ^ cc_q[0]);
        4'h6:    e_cnd_o = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
        default: e_cnd_o = 1'b0;
      endcase
    end
  end

  assign dst_e_sel = ((e_icode_i == I_CXX) && !e_cnd_o) ? RNONE : e_dstE_i;

`ifdef ALU_MUL_EN
  localparam logic [3:0]  F_MUL = 4'h4;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t              state_q, state_d;
  logic [2*DATA_W-1:0] prod_q, mcand_q;
  logic [DATA_W-1:0]   mplier_q, sv_val_a;
  logic [CNT_W-1:0]    cnt_q;
  logic [3:0]          sv_icode, sv_dst_e, sv_dst_m;

  assign mul_start = (state_q == S_IDLE) && is_op && (e_ifun_i == F_MUL) && !m_stall_i && !m_bubble_i;
  assign mul_emit  = (state_q == S_DONE) && !m_stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mul_start) state_d = S_MUL;
      S_MUL:   if (!m_stall_i && (cnt_q == CNT_W'(1))) state_d = S_DONE;
      S_DONE:  if (!m_stall_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Busy covers the result cycle too, so the instruction behind the multiply is held upstream
  always_comb begin
    busy_o = (state_q != S_IDLE);
  end

  // Bit 0 is folded in at entry; the remaining DATA_W-1 bits take one MUL cycle each
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sv_icode <= I_NOP;
      sv_val_a <= '0;
      sv_dst_e <= RNONE;
      sv_dst_m <= RNONE;
    end else if (mul_start) begin
      mcand_q  <= {{(DATA_W-1){1'b0}}, alu_b, 1'b0};
      mplier_q <= {1'b0, alu_a[MSB:1]};
      prod_q   <= alu_a[0] ? {{DATA_W{1'b0}}, alu_b} : '0;
      cnt_q    <= CNT_W'(DATA_W - 1);
      sv_icode <= e_icode_i;
      sv_val_a <= e_valA_i;
      sv_dst_e <= e_dstE_i;
      sv_dst_m <= e_dstM_i;
    end else if ((state_q == S_MUL) && !m_stall_i) begin
      if (mplier_q[0]) prod_q <= prod_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end
`else
  assign busy_o    = 1'b0;
  assign mul_start = 1'b0;
  assign mul_emit  = 1'b0;
`endif

  // Latch source and CC update: the live instruction, or the finished multiply
  always_comb begin
    src_icode = e_icode_i;
    src_cnd   = e_cnd_o;
    src_val_e = val_e;
    src_val_a = e_valA_i;
    src_dst_e = dst_e_sel;
    src_dst_m = e_dstM_i;
    cc_new    = {(val_e == '0), val_e[MSB], of_flag};
    cc_we     = is_op && alu_ok && set_cc_i && !m_stall_i && !m_bubble_i && !busy_o;
`ifdef ALU_MUL_EN
    if (state_q == S_DONE) begin
      src_icode = sv_icode;
      src_cnd   = 1'b0;
      src_val_e = prod_q[MSB:0];
      src_val_a = sv_val_a;
      src_dst_e = sv_dst_e;
      src_dst_m = sv_dst_m;
      cc_new    = {(prod_q[MSB:0] == '0), prod_q[MSB], |prod_q[2*DATA_W-1:DATA_W]};
      cc_we     = mul_emit && set_cc_i;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)      cc_q <= 3'b100;
    else if (cc_we) cc_q <= cc_new;
  end

  // E->M latch: stall holds; a finishing multiply always lands; otherwise bubble or load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_icode_o <= I_NOP;
      m_cnd_o   <= 1'b0;
      m_valE_o  <= '0;
      m_valA_o  <= '0;
      m_dstE_o  <= RNONE;
      m_dstM_o  <= RNONE;
    end else if (!m_stall_i) begin
      if (mul_emit || !(m_bubble_i || busy_o || mul_start)) begin
        m_icode_o <= src_icode;
        m_cnd_o   <= src_cnd;
        m_valE_o  <= src_val_e;
        m_valA_o  <= src_val_a;
        m_dstE_o  <= src_dst_e;
        m_dstM_o  <= src_dst_m;
      end else begin
        m_icode_o <= I_NOP;
        m_cnd_o   <= 1'b0;
        m_valE_o  <= '0;
        m_valA_o  <= '0;
        m_dstE_o  <= RNONE;
        m_dstM_o  <= RNONE;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed Y86 cases, stall/bubble control, random ALU traffic,
// and the multiplier sequence when ALU_MUL_EN is defined.
module tb_exec_stage;
  localparam int unsigned W = 64;
  localparam logic [3:0] I_NOP = 4'h1, I_CXX = 4'h2, I_IRMOVQ = 4'h3, I_RMMOVQ = 4'h4,
                         I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8,
                         I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB, I_IOPQ = 4'hC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, set_cc, m_stall, m_bubble, busy, e_cnd, m_cnd;
  logic [3:0]   e_icode, e_ifun, e_dste, e_dstm, m_icode, m_dste, m_dstm;
  logic [W-1:0] e_valc, e_vala, e_valb, m_vale, m_vala;

  exec_stage #(.DATA_W(W)) dut (
    .clk_i(clk), .rst_i(rst), .e_icode_i(e_icode), .e_ifun_i(e_ifun), .e_valC_i(e_valc),
    .e_valA_i(e_vala), .e_valB_i(e_valb), .e_dstE_i(e_dste), .e_dstM_i(e_dstm),
    .set_cc_i(set_cc), .m_stall_i(m_stall), .m_bubble_i(m_bubble), .busy_o(busy),
    .e_cnd_o(e_cnd), .m_icode_o(m_icode), .m_cnd_o(m_cnd), .m_valE_o(m_vale),
    .m_valA_o(m_vala), .m_dstE_o(m_dste), .m_dstM_o(m_dstm)
  );

  typedef struct {
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_out;
  exp_t        nop_out;
  logic [2:0]  cc_m;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic cond_ref(input logic [3:0] f, input logic [2:0] cc);
    logic z, s, o;
    z = cc[2]; s = cc[1]; o = cc[0];
    case (f)
      4'h0: return 1'b1;
      4'h1: return (s != o) || z;
      4'h2: return s != o;
      4'h3: return z;
      4'h4: return !z;
      4'h5: return s == o;
      4'h6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic compare_out(input string pfx, input exp_t e);
    check({pfx, "_icode"}, 64'(m_icode), 64'(e.icode));
    check({pfx, "_cnd"},   64'(m_cnd),   64'(e.cnd));
    check({pfx, "_valE"},  m_vale,       e.val_e);
    check({pfx, "_valA"},  m_vala,       e.val_a);
    check({pfx, "_dstE"},  64'(m_dste),  64'(e.dst_e));
    check({pfx, "_dstM"},  64'(m_dstm),  64'(e.dst_m));
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                       input logic [63:0] va, input logic [63:0] vb, input logic [3:0] de,
                       input logic [3:0] dm, input logic sc);
    e_icode = ic; e_ifun = fn; e_valc = vc; e_vala = va; e_valb = vb;
    e_dste = de; e_dstm = dm; set_cc = sc;
  endtask

  // Drive one instruction, predict its latch contents, clock it and compare
  task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                       input logic [63:0] va, input logic [63:0] vb, input logic [3:0] de,
                       input logic [3:0] dm, input logic sc);
    exp_t e;
    logic [63:0] a, b, r;
    logic        wr;
    logic [2:0]  ncc;
    drive(ic, fn, vc, va, vb, de, dm, sc);
    a = '0; b = '0; wr = 1'b0; ncc = cc_m;
    case (ic)
      I_CXX, I_OPQ:                         a = va;
      I_IRMOVQ, I_IOPQ, I_RMMOVQ, I_MRMOVQ: a = vc;
      I_CALL, I_PUSHQ:                      a = -64'd8;
      I_RET, I_POPQ:                        a = 64'd8;
      default: ;
    endcase
    case (ic)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_IOPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: b = vb;
      default: ;
    endcase
    if (ic == I_OPQ || ic == I_IOPQ) begin
      case (fn)
        4'h0: begin r = b + a; wr = 1'b1; ncc[0] = (a[63] == b[63]) && (r[63] != a[63]); end
        4'h1: begin r = b - a; wr = 1'b1; ncc[0] = (a[63] != b[63]) && (r[63] != b[63]); end
        4'h2: begin r = b & a; wr = 1'b1; ncc[0] = 1'b0; end
        4'h3: begin r = b ^ a; wr = 1'b1; ncc[0] = 1'b0; end
        default: r = '0;
      endcase
      ncc[2] = (r == '0);
      ncc[1] = r[63];
    end else begin
      r = b + a;
    end
    e.icode = ic;
    e.cnd   = (ic == I_JXX || ic == I_CXX) ? cond_ref(fn, cc_m) : 1'b0;
    e.val_e = r;
    e.val_a = va;
    e.dst_e = (ic == I_CXX && !e.cnd) ? 4'hF : de;
    e.dst_m = dm;
    #1;
    check("e_cnd", 64'(e_cnd), 64'(e.cnd));
    sb.push_back(e);
    @(posedge clk); #1;
    if (wr && sc) cc_m = ncc;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      compare_out("out", e);
      last_out = e;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(I_NOP, 4'h0, '0, '0, '0, 4'hF, 4'hF, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    cc_m = 3'b100;
    last_out = nop_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ic, fn;
    logic [63:0] x, y;
    int          busy_cnt, cyc;
    logic [3:0]  ic_set[12] = '{I_NOP, I_CXX, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ,
                                I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ, I_IOPQ};
    nop_out = '{icode: I_NOP, cnd: 1'b0, val_e: '0, val_a: '0, dst_e: 4'hF, dst_m: 4'hF};
    m_stall = 1'b0; m_bubble = 1'b0;
    do_reset();
    compare_out("rst", nop_out);
    check("rst_busy", 64'(busy), 64'(0));

    // Reset CC is Z=1: je taken, jne not taken
    issue(I_JXX, 4'h3, 64'h40, '0, '0, 4'hF, 4'hF, 1'b1);
    check("rst_cc_je", 64'(last_out.cnd), 64'(1));
    issue(I_JXX, 4'h4, 64'h40, '0, '0, 4'hF, 4'hF, 1'b1);

    // Signed overflow on ADD
    issue(I_OPQ, 4'h0, '0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'h3, 4'hF, 1'b1);
    check("add_ovf_valE", m_vale, 64'h8000_0000_0000_0000);
    issue(I_JXX, 4'h2, '0, '0, '0, 4'hF, 4'hF, 1'b1);
    check("ovf_jl", 64'(m_cnd), 64'(0));
    issue(I_JXX, 4'h5, '0, '0, '0, 4'hF, 4'hF, 1'b1);
    check("ovf_jge", 64'(m_cnd), 64'(1));
    issue(I_JXX, 4'h1, '0, '0, '0, 4'hF, 4'hF, 1'b1);

    // SUB to zero, then conditional moves
    issue(I_OPQ, 4'h1, '0, 64'd5, 64'd5, 4'h2, 4'hF, 1'b1);
    check("sub_zero_valE", m_vale, 64'd0);
    issue(I_CXX, 4'h3, '0, 64'd42, '0, 4'h7, 4'hF, 1'b1);
    check("cmove_dstE", 64'(m_dste), 64'(7));
    issue(I_CXX, 4'h4, '0, 64'd42, '0, 4'h7, 4'hF, 1'b1);
    check("cmovne_dstE", 64'(m_dste), 64'hF);

    // Stack adjust, CC untouched
    issue(I_PUSHQ, 4'h0, '0, 64'h55, 64'h100, 4'h4, 4'hF, 1'b1);
    check("push_valE", m_vale, 64'hF8);
    issue(I_POPQ, 4'h0, '0, 64'h55, 64'h100, 4'h4, 4'h1, 1'b1);
    check("pop_valE", m_vale, 64'h108);
    issue(I_JXX, 4'h3, '0, '0, '0, 4'hF, 4'hF, 1'b1);
    check("stack_cc_held", 64'(m_cnd), 64'(1));

`ifndef ALU_MUL_EN
    // ifun 4 without the multiplier: zero result, no CC write
    issue(I_OPQ, 4'h4, '0, 64'd3, 64'd7, 4'h1, 4'hF, 1'b1);
    issue(I_JXX, 4'h3, '0, '0, '0, 4'hF, 4'hF, 1'b1);
`endif

    // Stall, stall+bubble, bubble
    issue(I_OPQ, 4'h0, '0, 64'd1, 64'd2, 4'h3, 4'hF, 1'b1);
    drive(I_OPQ, 4'h1, '0, 64'd9, 64'd9, 4'h5, 4'hF, 1'b1);
    m_stall = 1'b1;
    @(posedge clk); #1;
    compare_out("stall", last_out);
    m_bubble = 1'b1;
    @(posedge clk); #1;
    compare_out("stall_bub", last_out);
    m_stall = 1'b0;
    @(posedge clk); #1;
    compare_out("bubble", nop_out);
    m_bubble = 1'b0;
    last_out = nop_out;
    issue(I_JXX, 4'h3, '0, '0, '0, 4'hF, 4'hF, 1'b1);
    check("stall_cc_held", 64'(m_cnd), 64'(0));

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      ic = ic_set[$urandom_range(0, 11)];
      fn = (ic == I_OPQ || ic == I_IOPQ) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      x = {$urandom, $urandom};
      y = ($urandom_range(0, 3) == 0) ? x : {$urandom, $urandom};
      issue(ic, fn, {$urandom, $urandom}, x, y, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

`ifdef ALU_MUL_EN
    // Multiply 7*3, holding the next instruction until busy drops
    drive(I_OPQ, 4'h4, '0, 64'd3, 64'd7, 4'h5, 4'hF, 1'b1);
    @(posedge clk); #1;
    drive(I_NOP, 4'h0, '0, '0, '0, 4'hF, 4'hF, 1'b1);
    check("mul_start_bubble", 64'(m_icode), 64'(I_NOP));
    busy_cnt = 0; cyc = 0;
    while (busy && cyc < 200) begin
      busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check("mul_busy_end", 64'(busy), 64'(0));
    check("mul_busy_cycles", 64'(busy_cnt), 64'(W));
    check("mul_icode", 64'(m_icode), 64'(I_OPQ));
    check("mul_valE", m_vale, 64'd21);
    check("mul_dstE", 64'(m_dste), 64'(5));
    cc_m = 3'b000;
    issue(I_JXX, 4'h6, '0, '0, '0, 4'hF, 4'hF, 1'b1);
    check("mul_cc_jg", 64'(m_cnd), 64'(1));

    // Reset in the middle of a multiply
    drive(I_OPQ, 4'h4, '0, 64'd3, 64'd7, 4'h5, 4'hF, 1'b1);
    @(posedge clk); #1;
    drive(I_NOP, 4'h0, '0, '0, '0, 4'hF, 4'hF, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("mul_mid_busy", 64'(busy), 64'(1));
    do_reset();
    check("mul_rst_busy", 64'(busy), 64'(0));
    compare_out("mul_rst", nop_out);
    repeat (W + 2) @(posedge clk);
    #1;
    check("mul_rst_idle", 64'(busy), 64'(0));
    check("mul_rst_discard", 64'(m_icode), 64'(I_NOP));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
